// File: rtl/adbg_param_fifo.sv
// adbg_param_fifo: parametrised synchronous FIFO between the JTAG shift logic
// and the bus-side engine of the advanced debug interface.
// Circular-buffer storage with first-word-fall-through head output.
// Ports:
//   CLK, RSTn      clock (rising edge) and asynchronous active-low reset
//   FLUSH          synchronous empty; overrides PUSH/POP in the same cycle
//   PUSH, DATA_IN  write request and data
//   POP            discard the head entry
//   DATA_OUT       head entry (0 when empty)
//   VALID, FULL, ALMOST_FULL, BYTES_AVAIL, BYTES_FREE  occupancy decode
//   OVERFLOW, UNDERFLOW  sticky error flags; CLR_ERR clears them
module adbg_param_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             FLUSH,
  input  logic             PUSH,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             POP,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID,
  output logic             FULL,
  output logic             ALMOST_FULL,
  output logic [CW-1:0]    BYTES_AVAIL,
  output logic [CW-1:0]    BYTES_FREE,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  input  logic             CLR_ERR
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full_c;
  logic             valid_c;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy decode from the registered count only.
  assign full_c    = (cnt_q == CW'(DEPTH));
  assign valid_c   = (cnt_q != '0);
  // A push into a full FIFO is accepted when the head is popped that cycle.
  assign push_ok_c = PUSH & (~full_c | POP);
  assign pop_ok_c  = POP & valid_c;

  // Next-state for pointers, count and sticky flags.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;

    if (FLUSH) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok_c) wp_d = ptr_inc(wp_q);
      if (pop_ok_c)  rp_d = ptr_inc(rp_q);
      unique case ({push_ok_c, pop_ok_c})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Clear first so a same-cycle error still sets the flag.
    if (CLR_ERR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!FLUSH && PUSH && full_c && !POP) ovf_d = 1'b1;
    if (!FLUSH && POP && !valid_c)        unf_d = 1'b1;
  end

  // Control state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage array; not reset.
  always_ff @(posedge CLK) begin
    if (!FLUSH && push_ok_c) mem[wp_q] <= DATA_IN;
  end

  // Head output is forced to zero when empty so stale storage never shows.
  assign DATA_OUT    = valid_c ? mem[rp_q] : '0;
  assign VALID       = valid_c;
  assign FULL        = full_c;
  assign ALMOST_FULL = (cnt_q >= CW'(AF_LEVEL));
  assign BYTES_AVAIL = cnt_q;
  assign BYTES_FREE  = CW'(DEPTH) - cnt_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule

// File: tb/tb_adbg_param_fifo.sv
// Testbench for adbg_param_fifo: default 8x8 instance plus a 16x5 instance
// for pointer wrap-around; queue-based scoreboard of expected contents.
module tb_adbg_param_fifo;

  logic clk;
  logic rst_n;

  // Default instance (WIDTH=8, DEPTH=8, AF_LEVEL=6)
  logic       a_flush, a_push, a_pop, a_clr;
  logic [7:0] a_din, a_dout;
  logic       a_valid, a_full, a_af, a_ovf, a_unf;
  logic [3:0] a_avail, a_free;

  // Wrap instance (WIDTH=16, DEPTH=5, AF_LEVEL=4)
  logic        b_flush, b_push, b_pop, b_clr;
  logic [15:0] b_din, b_dout;
  logic        b_valid, b_full, b_af, b_ovf, b_unf;
  logic [2:0]  b_avail, b_free;

  int errors;
  int checks;

  logic [7:0]  sb8[$];
  logic [15:0] sb5[$];
  logic        exp_ovf, exp_unf;

  adbg_param_fifo u_a (
    .CLK(clk), .RSTn(rst_n), .FLUSH(a_flush), .PUSH(a_push), .DATA_IN(a_din),
    .POP(a_pop), .DATA_OUT(a_dout), .VALID(a_valid), .FULL(a_full),
    .ALMOST_FULL(a_af), .BYTES_AVAIL(a_avail), .BYTES_FREE(a_free),
    .OVERFLOW(a_ovf), .UNDERFLOW(a_unf), .CLR_ERR(a_clr)
  );

  adbg_param_fifo #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4)) u_b (
    .CLK(clk), .RSTn(rst_n), .FLUSH(b_flush), .PUSH(b_push), .DATA_IN(b_din),
    .POP(b_pop), .DATA_OUT(b_dout), .VALID(b_valid), .FULL(b_full),
    .ALMOST_FULL(b_af), .BYTES_AVAIL(b_avail), .BYTES_FREE(b_free),
    .OVERFLOW(b_ovf), .UNDERFLOW(b_unf), .CLR_ERR(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus on the default instance; updates the model first.
  task automatic step8(input logic push, input logic [7:0] d, input logic pop,
                       input logic flush, input logic clr);
    int n;
    n = sb8.size();
    if (clr) begin
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end
    if (flush) begin
      sb8.delete();
    end else begin
      if (push && n == 8 && !pop) exp_ovf = 1'b1;
      if (pop && n == 0)          exp_unf = 1'b1;
      if (pop && n > 0)           void'(sb8.pop_front());
      if (push && (n < 8 || pop)) sb8.push_back(d);
    end
    a_push = push; a_din = d; a_pop = pop; a_flush = flush; a_clr = clr;
    @(posedge clk);
    #1;
    a_push = 1'b0; a_pop = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_din = '0;
  endtask

  // One clock of stimulus on the wrap instance.
  task automatic step5(input logic push, input logic [15:0] d, input logic pop);
    int n;
    n = sb5.size();
    if (pop && n > 0)           void'(sb5.pop_front());
    if (push && (n < 5 || pop)) sb5.push_back(d);
    b_push = push; b_din = d; b_pop = pop;
    @(posedge clk);
    #1;
    b_push = 1'b0; b_pop = 1'b0; b_din = '0;
  endtask

  task automatic test_reset;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", a_valid); end
    checks++;
    if (a_full !== 1'b0 || a_af !== 1'b0) begin errors++; $display("FAIL reset_full_af got=%0b%0b exp=00", a_full, a_af); end
    checks++;
    if (a_avail !== 4'd0 || a_free !== 4'd8) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/8", a_avail, a_free); end
    checks++;
    if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", a_dout); end
    checks++;
    if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL reset_errs got=%0b%0b exp=00", a_ovf, a_unf); end
    checks++;
    if (b_free !== 3'd5 || b_valid !== 1'b0) begin errors++; $display("FAIL reset_b got=%0d/%0b exp=5/0", b_free, b_valid); end
    checks++;
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
      if (a_avail !== 4'(i + 1) || a_free !== 4'(7 - i)) begin
        errors++; $display("FAIL fill_count[%0d] got=%0d/%0d exp=%0d/%0d", i, a_avail, a_free, i + 1, 7 - i);
      end
      checks++;
      if (a_af !== (i >= 5)) begin errors++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, a_af, i >= 5); end
      checks++;
    end
    if (a_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", a_full); end
    checks++;
    for (int i = 0; i < 8; i++) begin
      if (a_dout !== 8'(8'h11 + i) || a_dout !== sb8[0]) begin
        errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, a_dout, 8'(8'h11 + i));
      end
      checks++;
      step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    if (a_valid !== 1'b0 || a_dout !== 8'h00) begin errors++; $display("FAIL drain_empty got=%0b/%h exp=0/00", a_valid, a_dout); end
    checks++;
  endtask

  task automatic test_errors;
    for (int i = 0; i < 8; i++) step8(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0);
    step8(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    if (a_ovf !== 1'b1 || a_unf !== 1'b0) begin errors++; $display("FAIL ovf_set got=%0b%0b exp=10", a_ovf, a_unf); end
    checks++;
    if (a_avail !== 4'd8 || a_dout !== 8'h21) begin errors++; $display("FAIL ovf_nochange got=%0d/%h exp=8/21", a_avail, a_dout); end
    checks++;
    for (int i = 0; i < 8; i++) begin
      if (a_dout !== 8'(8'h21 + i)) begin errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, a_dout, 8'(8'h21 + i)); end
      checks++;
      step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    if (a_unf !== 1'b1 || a_avail !== 4'd0) begin errors++; $display("FAIL unf_set got=%0b/%0d exp=1/0", a_unf, a_avail); end
    checks++;
    step8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL clr_err got=%0b%0b exp=00", a_ovf, a_unf); end
    checks++;
    step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    if (a_unf !== 1'b1 || a_ovf !== 1'b0) begin errors++; $display("FAIL clr_vs_set got=%0b%0b exp=01", a_ovf, a_unf); end
    checks++;
    step8(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 8; i++) step8(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
    step8(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    if (a_avail !== 4'd8 || a_dout !== 8'h32 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL full_pushpop got=%0d/%h/%0b exp=8/32/0", a_avail, a_dout, a_ovf);
    end
    checks++;
    for (int i = 0; i < 7; i++) begin
      if (a_dout !== sb8[0]) begin errors++; $display("FAIL full_pp_drain[%0d] got=%h exp=%h", i, a_dout, sb8[0]); end
      checks++;
      step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    if (a_dout !== 8'hAA || a_avail !== 4'd1) begin errors++; $display("FAIL full_pp_tail got=%h/%0d exp=aa/1", a_dout, a_avail); end
    checks++;
    step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step8(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    if (a_avail !== 4'd1 || a_dout !== 8'h55 || a_unf !== 1'b1) begin
      errors++; $display("FAIL empty_pushpop got=%0d/%h/%0b exp=1/55/1", a_avail, a_dout, a_unf);
    end
    checks++;
    step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_wrap;
    int pushes;
    int occ;
    int op;
    pushes = 0;
    for (int it = 0; it < 300 && (pushes < 23 || sb5.size() > 0); it++) begin
      occ = sb5.size();
      if (b_avail !== 3'(occ) || 4'(b_avail) + 4'(b_free) !== 4'd5) begin
        errors++; $display("FAIL wrap_count[%0d] got=%0d/%0d exp=%0d", it, b_avail, b_free, occ);
      end
      checks++;
      if (pushes >= 23) op = 1;
      else if (occ < 2) op = 0;
      else if (occ >= 4) op = 1;
      else op = int'($urandom_range(0, 2));
      if (op != 0 && occ > 0) begin
        if (b_dout !== sb5[0]) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", it, b_dout, sb5[0]); end
        checks++;
      end
      case (op)
        0: begin step5(1'b1, 16'($urandom), 1'b0); pushes++; end
        1: step5(1'b0, 16'h0000, 1'b1);
        default: begin step5(1'b1, 16'($urandom), 1'b1); pushes++; end
      endcase
    end
    if (pushes != 23 || b_valid !== 1'b0 || b_unf !== 1'b0 || b_ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_end got=%0d/%0b/%0b%0b exp=23/0/00", pushes, b_valid, b_ovf, b_unf);
    end
    checks++;
  endtask

  task automatic test_flush;
    step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step8(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0);
    step8(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    if (a_avail !== 4'd0 || a_valid !== 1'b0 || a_free !== 4'd8 || a_dout !== 8'h00) begin
      errors++; $display("FAIL flush_state got=%0d/%0b/%0d/%h exp=0/0/8/00", a_avail, a_valid, a_free, a_dout);
    end
    checks++;
    if (a_unf !== 1'b1 || a_ovf !== 1'b0) begin errors++; $display("FAIL flush_errs got=%0b%0b exp=01", a_ovf, a_unf); end
    checks++;
    step8(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    if (a_dout !== 8'h77 || a_avail !== 4'd1) begin errors++; $display("FAIL flush_next got=%h/%0d exp=77/1", a_dout, a_avail); end
    checks++;
    step8(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) step8(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0);
    if (a_avail !== 4'd5) begin errors++; $display("FAIL arst_pre got=%0d exp=5", a_avail); end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    sb8.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (a_valid !== 1'b0 || a_avail !== 4'd0 || a_free !== 4'd8 || a_dout !== 8'h00 || a_full !== 1'b0) begin
      errors++; $display("FAIL arst_mid got=%0b/%0d/%0d/%h exp=0/0/8/00", a_valid, a_avail, a_free, a_dout);
    end
    checks++;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step8(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    if (a_dout !== 8'h3C || a_avail !== 4'd1) begin errors++; $display("FAIL arst_after got=%h/%0d exp=3c/1", a_dout, a_avail); end
    checks++;
    if (a_ovf !== exp_ovf || a_unf !== exp_unf) begin errors++; $display("FAIL arst_errs got=%0b%0b exp=%0b%0b", a_ovf, a_unf, exp_ovf, exp_unf); end
    checks++;
  endtask

  initial begin
    errors = 0; checks = 0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_din = '0;
    b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_fill_drain();
    test_errors();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
